// File: rtl/state_table_writer_pkg.sv
//------------------------------------------------------------------------------
// state_table_writer_pkg
//   Shared types and constants for the state-table programming block.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package state_table_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    WRITE = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [2:0] HDR_TAG     = 3'b101;
  localparam logic [7:0] CMD_COMMIT  = 8'hFF;
  localparam int         TABLE_DEPTH = 32;
  localparam int         ENTRY_W     = 6;
  localparam int         ADDR_W      = $clog2(TABLE_DEPTH);
  localparam int         CNT_W       = $clog2(TABLE_DEPTH + 1);

  function automatic logic is_header(input logic [7:0] b);
    return b[7:5] == HDR_TAG;
  endfunction

  // Data bytes carry the entry in [5:0]; the top two bits must be zero.
  function automatic logic is_data(input logic [7:0] b);
    return b[7:6] == 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/state_table_writer_table_ram.sv
//------------------------------------------------------------------------------
// table_ram
//   Table storage: one synchronous write port, one asynchronous read port.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module table_ram #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 6,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately never reset; readers qualify it with valid bits.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/state_table_writer.sv
//------------------------------------------------------------------------------
// state_table_writer
//   Byte-stream programmer for a 32x6 next-state table with a commit marker.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module state_table_writer
  import state_table_writer_pkg::*;
(
  input  logic               clk,
  input  logic               res,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               clr,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   wr_count
);

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_addr;
  logic [ENTRY_W-1:0]       r_entry;
  logic [TABLE_DEPTH-1:0]   r_valid;
  logic                     r_done;
  logic                     r_err;
  logic [CNT_W-1:0]         r_wr_count;

  logic                     w_accept;
  logic                     w_write;
  logic [ENTRY_W-1:0]       w_ram_rdata;

  assign in_ready = res && ((r_state == IDLE) || (r_state == DATA));
  assign w_accept = in_valid && in_ready;
  // A clear in the WRITE cycle wins, so the storage write is suppressed too.
  assign w_write  = (r_state == WRITE) && !clr;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_entry    <= '0;
      r_valid    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_count <= '0;
    end else if (clr) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (is_header(in_data)) begin
              r_state <= DATA;
              r_addr  <= in_data[ADDR_W-1:0];
              r_done  <= 1'b0;
            end else if (in_data == CMD_COMMIT) begin
              r_done  <= 1'b1;
            end else begin
              r_state <= ERR;
              r_err   <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            if (is_data(in_data)) begin
              r_state <= WRITE;
              r_entry <= in_data[ENTRY_W-1:0];
            end else begin
              r_state <= ERR;
              r_err   <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        WRITE: begin
          r_valid[r_addr] <= 1'b1;
          // Only first-time writes count; rewrites leave the tally alone.
          if (!r_valid[r_addr] && (r_wr_count < CNT_W'(TABLE_DEPTH))) begin
            r_wr_count <= r_wr_count + CNT_W'(1);
          end
          r_state <= IDLE;
        end
        ERR: begin
          r_state <= ERR;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  table_ram #(
    .DEPTH  (TABLE_DEPTH),
    .WIDTH  (ENTRY_W),
    .AWIDTH (ADDR_W)
  ) u_table_ram (
    .clk   (clk),
    .we    (w_write),
    .waddr (r_addr),
    .wdata (r_entry),
    .raddr (rd_addr),
    .rdata (w_ram_rdata)
  );

  assign rd_data  = r_valid[rd_addr] ? w_ram_rdata : '0;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign wr_count = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_state_table_writer.sv
//------------------------------------------------------------------------------
// tb_state_table_writer
//   Directed and randomized checks of state_table_writer against a frame model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/100ps

module tb_state_table_writer;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       clr = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [5:0] rd_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] wr_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int low_cnt  = 0;

  // Reference model: frame-level view of the table and status flags
  logic [5:0] m_mem   [32];
  logic       m_valid [32];
  int         m_count;
  logic       m_done, m_err, m_hdr;
  logic [4:0] m_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (res && !in_ready) low_cnt++;

  state_table_writer dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .wr_count(wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_count = 0; m_done = 1'b0; m_err = 1'b0; m_hdr = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_err) return;
    if (!m_hdr) begin
      if (b[7:5] == 3'b101) begin m_hdr = 1'b1; m_addr = b[4:0]; m_done = 1'b0; end
      else if (b == 8'hFF) m_done = 1'b1;
      else begin m_err = 1'b1; m_done = 1'b0; end
    end else begin
      m_hdr = 1'b0;
      if (b[7:6] == 2'b00) begin
        if (!m_valid[m_addr] && m_count < 32) m_count++;
        m_valid[m_addr] = 1'b1;
        m_mem[m_addr]   = b[5:0];
      end else begin
        m_err = 1'b1; m_done = 1'b0;
      end
    end
  endtask

  // Offer a byte and return at the negedge right after it is accepted.
  task automatic xfer(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    assert (n < 20) else begin
      n_fail++;
      $error("FAIL accept_timeout observed=%0d expected=<20", n);
    end
    @(negedge clk);
    model_byte(b);
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ignored_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    chk("ready_in_err", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    res = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    res = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, wr_count, m_count);
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_busy"}, busy, m_hdr || m_err);
    chk({tag, "_ready"}, in_ready, !m_err);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #0.1;
      chk({tag, "_rd"}, rd_data, m_valid[i] ? m_mem[i] : 6'h00);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [4:0] a;
    logic [5:0] d;
    int t0, lc0;
    model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = 6'h00;

    // Power-on reset and empty-table sweep
    apply_reset();
    check_status("reset");
    check_table("empty");

    // Two frames, read timing and one-cycle ready gap per frame
    lc0 = low_cnt;
    rd_addr = 5'd0;
    xfer(8'hA0);
    xfer(8'h13);
    in_valid = 1'b0;
    #0.1;
    chk("no_bypass", rd_data, 6'h00);
    @(negedge clk);
    chk("visible_after_write", rd_data, 6'h13);
    xfer(8'hA1);
    xfer(8'h14);
    settle();
    chk("ready_low_cycles", low_cnt - lc0, 2);
    check_status("two_frames");
    check_table("two_frames");

    // Rewrite does not count; commit sets done
    apply_reset();
    xfer(8'hA5); xfer(8'h12);
    xfer(8'hA5); xfer(8'h29);
    xfer(8'hFF);
    settle();
    check_status("rewrite_commit");
    rd_addr = 5'd5; #0.1;
    chk("rewrite_val", rd_data, 6'h29);
    chk("commit_done", done, 1'b1);
    xfer(8'hA6);
    settle();
    chk("hdr_clears_done", done, 1'b0);
    xfer(8'h07);
    settle();

    // Framing error is sticky until clr, which also drops valid bits
    xfer(8'h60);
    settle();
    chk("err_set", err, 1'b1);
    ignored_byte(8'hA2);
    ignored_byte(8'hC0);
    check_status("err_sticky");
    pulse_clr();
    @(negedge clk);
    check_status("after_clr");
    check_table("after_clr");

    // clr coincident with an accepted header drops that header
    in_valid = 1'b1; in_data = 8'hA4; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check_status("clr_wins");

    // Reset mid-frame abandons the write
    apply_reset();
    xfer(8'hA3);
    in_valid = 1'b0;
    apply_reset();
    check_status("mid_frame_reset");
    rd_addr = 5'd3; #0.1;
    chk("mid_frame_rd3", rd_data, 6'h00);

    // All 32 addresses back-to-back: 3 cycles per entry, saturating count
    apply_reset();
    t0 = cyc;
    for (int i = 0; i < 32; i++) begin
      xfer({3'b101, 5'(i)});
      xfer({2'b00, 6'($urandom)});
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_cycles", cyc - t0, 96);
    check_status("full");
    check_table("full");
    xfer(8'hA9); xfer(8'h3F);
    settle();
    check_status("saturate");

    // Randomized mix of frames, commits, errors and clears
    for (int it = 0; it < 150; it++) begin
      a = 5'($urandom);
      d = 6'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin xfer({3'b101, a}); xfer({2'b00, d}); end
        6: xfer(8'hFF);
        7: begin
          do b = 8'($urandom); while (b[7:5] == 3'b101 || b == 8'hFF);
          xfer(b);
          settle();
          check_status("rnd_err");
          ignored_byte(8'($urandom));
          pulse_clr();
        end
        8: begin
          in_valid = 1'b1; in_data = {3'b101, a}; clr = 1'b1;
          @(negedge clk);
          clr = 1'b0; in_valid = 1'b0;
          model_clear();
        end
        default: begin
          xfer({3'b101, a});
          xfer({2'($urandom_range(1, 3)), d});
          settle();
          check_status("rnd_bad_data");
          pulse_clr();
        end
      endcase
      settle();
      check_status("rnd");
      if (it % 25 == 24) check_table("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
